// File: rtl/alu_32bit_seq.sv
// Sequential 32-bit ALU with a valid/ready handshake on each side.
// Logic ops complete in one cycle; SLL/SRL shift one bit per cycle.
module alu_32bit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0010;
  localparam logic [3:0] OpOr  = 4'b0011;
  localparam logic [3:0] OpXor = 4'b0100;
  localparam logic [3:0] OpSll = 4'b0101;
  localparam logic [3:0] OpSrl = 4'b0110;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [4:0]       cnt_q;
  logic             dir_right_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;

  logic             accept;
  logic             is_shift;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;
  logic [WIDTH-1:0] acc_shifted;
  logic             load_en;
  logic [WIDTH-1:0] load_val;
  logic             load_illegal;

  assign accept   = in_valid && (state_q == StIdle);
  assign is_shift = (op == OpSll) || (op == OpSrl);
  assign shamt    = b[4:0];

  // Single-cycle operations; carry and borrow fall off the top.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (op)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpSll:   alu_res = a;
      OpSrl:   alu_res = a;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign acc_shifted = dir_right_q ? (acc_q >> 1) : (acc_q << 1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_shift && (shamt != 5'd0)) begin
            state_d = StShift;
          end else begin
            state_d = StDone;
          end
        end
      end
      StShift: begin
        if (cnt_q == 5'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle:  in_ready  = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Result register is written only when an operation completes, so it
  // holds steady through any amount of output backpressure.
  always_comb begin
    load_en      = 1'b0;
    load_val     = '0;
    load_illegal = 1'b0;
    if (accept && !(is_shift && (shamt != 5'd0))) begin
      load_en      = 1'b1;
      load_val     = alu_res;
      load_illegal = alu_illegal;
    end else if ((state_q == StShift) && (cnt_q == 5'd1)) begin
      load_en  = 1'b1;
      load_val = acc_shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= 5'd0;
      dir_right_q <= 1'b0;
    end else if (accept && is_shift) begin
      acc_q       <= a;
      cnt_q       <= shamt;
      dir_right_q <= (op == OpSrl);
    end else if (state_q == StShift) begin
      acc_q <= acc_shifted;
      cnt_q <= cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else if (load_en) begin
      result_q  <= load_val;
      zero_q    <= (load_val == '0);
      illegal_q <= load_illegal;
    end
  end

  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_32bit_seq.sv
// Self-checking bench for alu_32bit_seq: directed vectors, backpressure,
// mid-operation reset and random operations against a behavioural model.
module tb_alu_32bit_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int cmp;
  int errs;

  alu_32bit_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: what the opcode means, and how long it takes.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] mop,
                       output logic [31:0] res, output logic ill, output int lat);
    int n;
    n   = int'(mb[4:0]);
    ill = 1'b0;
    lat = 1;
    case (mop)
      4'd0: res = ma + mb;
      4'd1: res = ma - mb;
      4'd2: res = ma & mb;
      4'd3: res = ma | mb;
      4'd4: res = ma ^ mb;
      4'd5: begin res = ma << n; lat = n + 1; end
      4'd6: begin res = ma >> n; lat = n + 1; end
      default: begin res = 32'd0; ill = 1'b1; end
    endcase
  endtask

  // One transaction: accept, scramble inputs, time the result, hold, hand off.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [3:0] top, input logic [31:0] exp_res, input logic exp_ill,
                        input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    op        = top;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'($urandom_range(0, 1));
    a        = $urandom;
    b        = $urandom;
    op       = 4'($urandom_range(0, 15));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, result, exp_res);
    check({tag, ".zero"}, 32'(zero), 32'(exp_res == 32'd0));
    check({tag, ".illegal"}, 32'(illegal_op), 32'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, ".hold_result"}, result, exp_res);
      check({tag, ".hold_zero"}, 32'(zero), 32'(exp_res == 32'd0));
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".handoff_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".handoff_in_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic run_rand(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [3:0] top, input int hold);
    logic [31:0] r;
    logic        il;
    int          l;
    model(ta, tb_v, top, r, il, l);
    run_op(tag, ta, tb_v, top, r, il, l, hold);
  endtask

  initial begin
    cmp       = 0;
    errs      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.zero", 32'(zero), 32'd1);
    check("reset.illegal", 32'(illegal_op), 32'd0);
    rst_n = 1'b1;

    run_op("add", 32'h12345678, 32'h87654321, 4'd0, 32'h99999999, 1'b0, 1, 0);
    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 4'd0, 32'h00000000, 1'b0, 1, 0);
    run_op("sub", 32'h12345678, 32'h87654321, 4'd1, 32'h8ACF1357, 1'b0, 1, 0);
    run_op("xor", 32'h12345678, 32'h12345678, 4'd4, 32'h00000000, 1'b0, 1, 0);
    run_op("and", 32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000, 1'b0, 1, 0);
    run_op("or", 32'hF0F0F0F0, 32'hFF00FF00, 4'd3, 32'hFFF0FFF0, 1'b0, 1, 0);
    run_op("sll4", 32'h12345678, 32'h00000004, 4'd5, 32'h23456780, 1'b0, 5, 0);
    run_op("srl1", 32'h00000001, 32'h00000001, 4'd6, 32'h00000000, 1'b0, 2, 0);
    run_op("sll32", 32'h12345678, 32'h00000020, 4'd5, 32'h12345678, 1'b0, 1, 0);
    run_op("srl31", 32'h80000000, 32'hFFFFFFFF, 4'd6, 32'h00000001, 1'b0, 32, 0);
    run_op("illegal", 32'h12345678, 32'h87654321, 4'hF, 32'h00000000, 1'b1, 1, 0);
    run_op("backpressure", 32'h0000BEEF, 32'h00010000, 4'd0, 32'h0001BEEF, 1'b0, 1, 10);

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'hFFFFFFFF;
    b        = 32'd31;
    op       = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid.busy", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.result", result, 32'd0);
    check("rst_mid.zero", 32'(zero), 32'd1);
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 32'd1, 32'd1, 4'd0, 32'd2, 1'b0, 1, 0);

    for (int i = 0; i < 30; i++) begin
      int r;
      logic [3:0] rop;
      r   = int'($urandom_range(0, 9));
      rop = (r < 7) ? 4'(r) : 4'($urandom_range(7, 15));
      run_rand($sformatf("rand%0d", i), $urandom, $urandom, rop, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
